// File: rtl/gpio_port_in_pkg.sv
// Shared constants for the 8-bit port input block: register offsets, PxIV codes,
// register-select enum and small decode helpers used by the top level.
package gpio_port_in_pkg;

    localparam logic [15:0] OFF_IN  = 16'h0000;
    localparam logic [15:0] OFF_IV  = 16'h000E;
    localparam logic [15:0] OFF_IES = 16'h0018;
    localparam logic [15:0] OFF_IE  = 16'h001A;
    localparam logic [15:0] OFF_IFG = 16'h001C;

    localparam logic [15:0] IV_NONE = 16'h0000;
    localparam logic [15:0] IV_BIT0 = 16'h0002;
    localparam logic [15:0] IV_BIT1 = 16'h0004;
    localparam logic [15:0] IV_BIT2 = 16'h0006;
    localparam logic [15:0] IV_BIT3 = 16'h0008;
    localparam logic [15:0] IV_BIT4 = 16'h000A;
    localparam logic [15:0] IV_BIT5 = 16'h000C;
    localparam logic [15:0] IV_BIT6 = 16'h000E;
    localparam logic [15:0] IV_BIT7 = 16'h0010;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_IN,
        SEL_IV,
        SEL_IES,
        SEL_IE,
        SEL_IFG
    } regSel_e;

    // Exact 16-bit match, so odd byte addresses never select a register.
    function automatic regSel_e decodeAddr(input logic [15:0] addr, input logic [15:0] base);
        regSel_e sel;
        sel = SEL_NONE;
        if      (addr == 16'(base + OFF_IN))  sel = SEL_IN;
        else if (addr == 16'(base + OFF_IV))  sel = SEL_IV;
        else if (addr == 16'(base + OFF_IES)) sel = SEL_IES;
        else if (addr == 16'(base + OFF_IE))  sel = SEL_IE;
        else if (addr == 16'(base + OFF_IFG)) sel = SEL_IFG;
        return sel;
    endfunction

    // Lowest set flag has the highest priority.
    function automatic logic [15:0] ivEncode(input logic [7:0] ifg);
        logic [15:0] iv;
        casez (ifg)
            8'b???????1: iv = IV_BIT0;
            8'b??????10: iv = IV_BIT1;
            8'b?????100: iv = IV_BIT2;
            8'b????1000: iv = IV_BIT3;
            8'b???10000: iv = IV_BIT4;
            8'b??100000: iv = IV_BIT5;
            8'b?1000000: iv = IV_BIT6;
            8'b10000000: iv = IV_BIT7;
            default:     iv = IV_NONE;
        endcase
        return iv;
    endfunction

    function automatic logic [7:0] lowestBit(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/gpio_port_in_if.sv
// Peripheral memory bus seen by the port: byte address, write data, strobes, read data.
interface gpio_port_in_if;

    logic [15:0] MAB;
    logic [15:0] MDB_in;
    logic        MW;
    logic        MR;
    logic [15:0] MDB_out;

    modport master (
        output MAB,
        output MDB_in,
        output MW,
        output MR,
        input  MDB_out
    );

    modport slave (
        input  MAB,
        input  MDB_in,
        input  MW,
        input  MR,
        output MDB_out
    );

endinterface

// File: rtl/gpio_port_in_sync.sv
// WIDTH x STAGES flop-chain synchroniser with async active-low reset.
// Every stage is exported so the caller can tap the last two for edge detection.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rstN_i,
    input  logic [WIDTH-1:0]              data_i,
    output logic [STAGES-1:0][WIDTH-1:0]  stages_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign stages_o = stage_q;

endmodule

// File: rtl/gpio_port_in.sv
// Input half of an 8-bit MSP430-style port: pad synchroniser, PxIN, edge interrupts
// (PxIES/PxIE/PxIFG) and the PxIV vector with read-to-clear. SYNC_STAGES must be 2 or 3.
module gpio_port_in
    import gpio_port_in_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'h0200,
    parameter int          SYNC_STAGES = 2
) (
    input  logic           MCLK,
    input  logic           RST_n,
    input  logic [7:0]     PAD_IN,
    gpio_port_in_if.slave  bus,
    output logic           INT
);

    localparam logic [1:0] ARM_DONE = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0][7:0] syncStages;
    logic [7:0]  pxIn;
    logic [7:0]  newest;
    logic [7:0]  riseEdge;
    logic [7:0]  fallEdge;
    logic [7:0]  hwSet;
    logic [7:0]  ivClr;
    logic [7:0]  ifgBase;
    logic [15:0] pxIv;
    logic        armed;
    logic        writeEn;
    logic        readEn;
    regSel_e     regSel;
    logic        unusedMdbHi;

    logic [1:0]  armCnt_q,  armCnt_d;
    logic [7:0]  pxIes_q,   pxIes_d;
    logic [7:0]  pxIe_q,    pxIe_d;
    logic [7:0]  pxIfg_q,   pxIfg_d;

    gpio_sync #(
        .WIDTH  (8),
        .STAGES (SYNC_STAGES)
    ) uSync (
        .clk_i    (MCLK),
        .rstN_i   (RST_n),
        .data_i   (PAD_IN),
        .stages_o (syncStages)
    );

    assign pxIn        = syncStages[SYNC_STAGES-1];
    assign newest      = syncStages[SYNC_STAGES-2];
    assign unusedMdbHi = ^bus.MDB_in[15:8];

    assign regSel  = decodeAddr(bus.MAB, BASE);
    assign writeEn = bus.MW && (regSel != SEL_NONE);
    assign readEn  = bus.MR && (regSel != SEL_NONE);

    // Edges are masked until the synchroniser has been refilled after reset,
    // so the pad state present at reset release never raises a flag.
    assign armed    = (armCnt_q == ARM_DONE);
    assign armCnt_d = armed ? armCnt_q : armCnt_q + 2'd1;

    assign riseEdge = newest & ~pxIn;
    assign fallEdge = ~newest & pxIn;
    assign hwSet    = armed ? ((pxIes_q & fallEdge) | (~pxIes_q & riseEdge)) : 8'h00;

    assign pxIv  = ivEncode(pxIfg_q);
    assign ivClr = (readEn && (regSel == SEL_IV)) ? lowestBit(pxIfg_q) : 8'h00;

    // Software writes and IV clears first, hardware set ORed last so it always wins.
    always_comb begin
        pxIes_d = pxIes_q;
        pxIe_d  = pxIe_q;
        ifgBase = pxIfg_q & ~ivClr;
        if (writeEn) begin
            case (regSel)
                SEL_IES: pxIes_d = bus.MDB_in[7:0];
                SEL_IE:  pxIe_d  = bus.MDB_in[7:0];
                SEL_IFG: ifgBase = bus.MDB_in[7:0];
                default: ;
            endcase
        end
        pxIfg_d = ifgBase | hwSet;
    end

    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) begin
            armCnt_q <= '0;
            pxIes_q  <= '0;
            pxIe_q   <= '0;
            pxIfg_q  <= '0;
        end else begin
            armCnt_q <= armCnt_d;
            pxIes_q  <= pxIes_d;
            pxIe_q   <= pxIe_d;
            pxIfg_q  <= pxIfg_d;
        end
    end

    always_comb begin
        bus.MDB_out = 16'h0000;
        if (readEn) begin
            case (regSel)
                SEL_IN:  bus.MDB_out = {8'h00, pxIn};
                SEL_IV:  bus.MDB_out = pxIv;
                SEL_IES: bus.MDB_out = {8'h00, pxIes_q};
                SEL_IE:  bus.MDB_out = {8'h00, pxIe_q};
                SEL_IFG: bus.MDB_out = {8'h00, pxIfg_q};
                default: bus.MDB_out = 16'h0000;
            endcase
        end
    end

    assign INT = |(pxIfg_q & pxIe_q);

endmodule

// File: tb/tb_gpio_port_in.sv
// Directed bench for gpio_port_in: expectations are queued when stimulus is driven
// and popped when the DUT output is sampled, half a cycle away from the rising edge.
module tb_gpio_port_in;

    localparam logic [15:0] A_IN  = 16'h0200;
    localparam logic [15:0] A_IV  = 16'h020E;
    localparam logic [15:0] A_IES = 16'h0218;
    localparam logic [15:0] A_IE  = 16'h021A;
    localparam logic [15:0] A_IFG = 16'h021C;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } expect_t;

    logic       MCLK;
    logic       RST_n;
    logic [7:0] PAD_IN;
    logic       INT;

    expect_t sbQ[$];
    int      assertCount = 0;
    int      failCount   = 0;

    gpio_port_in_if busIf();

    gpio_port_in #(
        .BASE        (16'h0200),
        .SYNC_STAGES (2)
    ) dut (
        .MCLK   (MCLK),
        .RST_n  (RST_n),
        .PAD_IN (PAD_IN),
        .bus    (busIf),
        .INT    (INT)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic pushExpect(input string tag, input logic [15:0] val);
        expect_t e;
        e.tag = tag;
        e.val = val;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [15:0] observed);
        expect_t e;
        assertCount++;
        if (sbQ.size() == 0) begin
            failCount++;
            $error("FAIL scoreboard_empty: observed %h expected <queued value>", observed);
        end else begin
            e = sbQ.pop_front();
            assert (observed === e.val)
            else begin
                failCount++;
                $error("FAIL %s: observed %h expected %h", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pad);
        PAD_IN = pad;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge MCLK);
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
        busIf.MAB    = addr;
        busIf.MDB_in = data;
        busIf.MW     = 1'b1;
        @(negedge MCLK);
        busIf.MW     = 1'b0;
    endtask

    task automatic busRead(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        busIf.MAB = addr;
        busIf.MR  = 1'b1;
        pushExpect(tag, exp);
        #1;
        checkOutput(busIf.MDB_out);
        @(negedge MCLK);
        busIf.MR  = 1'b0;
    endtask

    task automatic checkInt(input logic exp, input string tag);
        pushExpect(tag, {15'h0000, exp});
        checkOutput({15'h0000, INT});
    endtask

    initial begin
        RST_n        = 1'b0;
        busIf.MAB    = 16'h0000;
        busIf.MDB_in = 16'h0000;
        busIf.MW     = 1'b0;
        busIf.MR     = 1'b0;
        applyStimulus(8'hA5);
        tick(1);

        $display("[TB] T1 reset");
        busRead(A_IN,  16'h0000, "rst_in");
        busRead(A_IV,  16'h0000, "rst_iv");
        busRead(A_IES, 16'h0000, "rst_ies");
        busRead(A_IE,  16'h0000, "rst_ie");
        busRead(A_IFG, 16'h0000, "rst_ifg");
        checkInt(1'b0, "rst_int");
        RST_n = 1'b1;
        busRead(A_IN, 16'h0000, "rel_in_edge0");
        busRead(A_IN, 16'h0000, "rel_in_edge1");
        busRead(A_IN, 16'h00A5, "rel_in_edge2");
        tick(3);
        busRead(A_IFG, 16'h0000, "rel_ifg_quiet");

        $display("[TB] T2 rising edge");
        busWrite(A_IES, 16'h0000);
        busWrite(A_IE,  16'h0001);
        applyStimulus(8'hA4);
        tick(3);
        busRead(A_IFG, 16'h0000, "t2_fall_no_flag");
        applyStimulus(8'hA5);
        tick(1);
        checkInt(1'b0, "t2_int_edge1");
        busRead(A_IFG, 16'h0000, "t2_ifg_edge1");
        checkInt(1'b1, "t2_int_edge2");
        busRead(A_IFG, 16'h0001, "t2_ifg_edge2");
        busRead(A_IN,  16'h00A5, "t2_in");
        busRead(A_IV,  16'h0002, "t2_iv_bit0");
        checkInt(1'b0, "t2_int_cleared");
        busRead(A_IFG, 16'h0000, "t2_ifg_cleared");

        $display("[TB] T3 falling edge");
        busWrite(A_IES, 16'h0080);
        busWrite(A_IE,  16'h0080);
        busRead(A_IFG, 16'h0000, "t3_ies_write_no_flag");
        applyStimulus(8'h25);
        tick(2);
        checkInt(1'b1, "t3_int");
        busRead(A_IFG, 16'h0080, "t3_ifg");
        busRead(A_IV,  16'h0010, "t3_iv_bit7");
        checkInt(1'b0, "t3_int_cleared");
        busRead(A_IFG, 16'h0000, "t3_ifg_cleared");
        applyStimulus(8'hA5);
        tick(3);
        busRead(A_IFG, 16'h0000, "t3_rise_ignored");

        $display("[TB] T4 priority");
        busWrite(A_IE,  16'h0000);
        busWrite(A_IFG, 16'h0022);
        checkInt(1'b0, "t4_int_masked");
        busRead(A_IV, 16'h0004, "t4_iv_bit1");
        busRead(A_IV, 16'h000C, "t4_iv_bit5");
        busRead(A_IV, 16'h0000, "t4_iv_empty");
        busRead(A_IV, 16'h0000, "t4_iv_empty_again");
        busRead(A_IFG, 16'h0000, "t4_ifg_empty");
        checkInt(1'b0, "t4_int_final");
        busWrite(16'h021B, 16'h00FF);
        busRead(A_IE, 16'h0000, "t4_odd_write_ignored");
        busRead(16'h021D, 16'h0000, "t4_odd_read_zero");
        busRead(16'h0202, 16'h0000, "t4_unmapped_read_zero");

        $display("[TB] T5 collisions");
        applyStimulus(8'hAD);
        tick(1);
        busWrite(A_IFG, 16'h0000);
        busRead(A_IFG, 16'h0008, "t5_hw_beats_sw_write");
        busWrite(A_IFG, 16'h0000);
        applyStimulus(8'hA9);
        tick(3);
        busWrite(A_IFG, 16'h0004);
        applyStimulus(8'hAD);
        tick(1);
        busRead(A_IV,  16'h0006, "t5_iv_bit2");
        busRead(A_IFG, 16'h0004, "t5_hw_beats_iv_clear");

        $display("[TB] T6 async reset mid-operation");
        busWrite(A_IE,  16'h00FF);
        busWrite(A_IFG, 16'h00FF);
        checkInt(1'b1, "t6_int_before");
        busRead(A_IFG, 16'h00FF, "t6_ifg_before");
        #2;
        RST_n = 1'b0;
        #1;
        checkInt(1'b0, "t6_int_async");
        busRead(A_IFG, 16'h0000, "t6_ifg_async");
        busRead(A_IE,  16'h0000, "t6_ie_async");
        RST_n = 1'b1;
        tick(4);
        busRead(A_IFG, 16'h0000, "t6_no_flag_after_release");
        busRead(A_IN,  16'h00AD, "t6_in_after_release");
        checkInt(1'b0, "t6_int_after_release");

        if (sbQ.size() != 0) begin
            assertCount++;
            failCount++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sbQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
